uart_byte_rx: RTL
=================

// Module: uart_byte_rx
// PURPOSE
//  Serial-to-byte receiver: turns the host UART line into a one-cycle-strobed byte
//  stream (data_out/valid_out). That stream drives the data_in/valid_in port of the
//  RAM write bridge, which parses 'W' + 4 addr + 5 data bytes into BRAM writes.
//  Runs in the pixel clock domain; rx_in is asynchronous and synchronized internally.
// PARAMETERS
//  CLK_HZ   74_250_000  clock frequency in Hz
//  BAUD     115_200     line rate; CPB = CLK_HZ/BAUD (integer division), must be >= 4
// PORTS
//  clk_in           in   1  system/pixel clock; all logic on posedge
//  rst_in           in   1  synchronous, active-high reset
//  rx_in            in   1  async UART line, idle high, 8N1 (8E1 with parity macro)
//  data_out         out  8  last received byte, LSB first on wire; held until next valid
//  valid_out        out  1  one-cycle strobe: data_out holds a new good byte
//  framing_err_out  out  1  one-cycle strobe: stop bit sampled low
//  parity_err_out   out  1  one-cycle strobe: parity mismatch (constant 0 without macro)
// BEHAVIOUR
//  - Reset (rst_in high at posedge): state=IDLE, counters=0, both sync flops=1,
//    data_out=0, valid_out=0, framing_err_out=0, parity_err_out=0. Wins over all.
//    Asserted mid-frame: partial byte discarded, no strobes.
//  - Sync: 2-flop synchronizer, reset to 1; FSM sees rx_s (2-cycle delay).
//  - Strobes default 0 every cycle; at most one of the three high per cycle.
//  - States/transitions:
//    IDLE:  rx_s==0 -> START, bit counter=0, cycle counter=0.
//    START: wait CPB/2 cycles (mid start bit); sample rx_s: 1 -> IDLE (glitch
//           rejected, no strobe); 0 -> DATA, cycle counter=0.
//    DATA:  every CPB cycles sample rx_s into shift reg bit[n], n=0..7 (LSB first);
//           after bit 7 -> PARITY (macro on) or STOP.
//    PARITY:after CPB cycles sample; even parity over 8 data bits + parity bit.
//           Error latched, reported at STOP.
//    STOP:  after CPB cycles sample rx_s:
//           1 & no parity error -> data_out<=shift reg, valid_out=1 next cycle, IDLE.
//           1 & parity error -> parity_err_out=1, data_out unchanged, IDLE.
//           0 -> framing_err_out=1, data_out unchanged, BREAK.
//    BREAK: wait until rx_s==1, then IDLE (no new frame until line returns high).
//  - Return to IDLE at mid stop bit, so back-to-back frames with zero idle gap
//    are received; next start edge seen at most CPB/2 + 2 cycles late.
//  - Latency: valid_out rises CPB/2 + 9*CPB (+CPB w/ parity) + 3 +/- 1 cycles
//    after the rx_in falling edge.
//  - Counters: cycle counter width $clog2(CPB)+1, saturation never reached; bit
//    counter 3 bits, no wrap past 7. No backpressure: consumer must take each
//    strobe (downstream bridge accepts one byte per cycle).
// CONFIGURATION
//  - UART_RX_PARITY_EN defined: 8E1 frames, PARITY state present, parity_err_out live.
//  - Undefined: 8N1 frames, no PARITY state, parity_err_out tied 0; a 9th bit
//    position is treated as the stop bit.
// TESTING  (bench: CLK_HZ=800, BAUD=100 -> CPB=8; ideal 8-cycle bits)
//  1. Idle 20 cycles, send 0x57 -> exactly one valid_out, data_out=0x57, no errors,
//     ~79 cycles after start edge.
//  2. rx_in low 2 cycles then high -> no strobe, FSM in IDLE; then 0xA5 -> valid, 0xA5.
//  3. 0x3C with stop bit low, line held low 24 cycles -> one framing_err_out,
//     no valid, data_out unchanged; high 8 cycles, send 0x01 -> valid, data_out=0x01.
//  4. "W",01,00,00,00,EF,BE,AD,DE,0F back-to-back, no gap -> 10 valid pulses,
//     values in order, no errors.
//  5. rst_in one cycle during data bit 4 of 0xFF -> all outputs 0 next cycle,
//     no strobe for that frame; following 0x42 -> valid, data_out=0x42.
//  6. (UART_RX_PARITY_EN) 0x07 with parity bit 0 -> parity_err_out only;
//     0x07 with parity bit 1 -> valid_out, data_out=0x07.

Source files
------------

// File: rtl/uart_byte_rx_if.sv
// rtl/uart_byte_rx_if.sv - serial line and received-byte stream of the UART byte receiver
//
// Purpose: bundles the asynchronous UART line with the strobed byte/error outputs.
// Signals:
//   rx_in            async UART line, idle high
//   data_out[7:0]    last good byte, held until the next valid_out
//   valid_out        one-cycle strobe, data_out holds a new byte
//   framing_err_out  one-cycle strobe, stop bit sampled low
//   parity_err_out   one-cycle strobe, parity mismatch
// Modports: master = receiver side, slave = line driver / byte consumer side.

interface uart_byte_rx_if;
    logic       rx_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       framing_err_out;
    logic       parity_err_out;

    modport master (
        input  rx_in,
        output data_out,
        output valid_out,
        output framing_err_out,
        output parity_err_out
    );

    modport slave (
        output rx_in,
        input  data_out,
        input  valid_out,
        input  framing_err_out,
        input  parity_err_out
    );
endinterface

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - UART 8N1/8E1 serial-to-byte receiver with one-cycle strobes
//
// Purpose: oversamples an asynchronous UART line (CPB = CLK_HZ/BAUD clocks per bit,
// CPB >= 4), samples each bit at its midpoint and emits received bytes as a
// one-cycle valid_out strobe with data_out held until the next good byte.
// Optional feature macro: UART_RX_PARITY_EN (8E1 frames, even parity checked).
// Ports:
//   clk_in   in  clock, all logic on posedge
//   rst_in   in  synchronous active-high reset
//   bus      uart_byte_rx_if.master: rx_in in; data_out, valid_out,
//            framing_err_out, parity_err_out out

module uart_byte_rx #(
    parameter int CLK_HZ = 74_250_000,
    parameter int BAUD   = 115_200
) (
    input  logic           clk_in,
    input  logic           rst_in,
    uart_byte_rx_if.master bus
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] CYC_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    logic          rx_meta;
    logic          rx_s;
    state_t        state_q, state_n;
    logic [CW-1:0] cyc_q, cyc_n;
    logic [2:0]    bit_q, bit_n;
    logic [7:0]    shift_q, shift_n;
    logic [7:0]    data_q, data_n;
    logic          valid_q, valid_n;
    logic          ferr_q, ferr_n;
    logic          perr_q, perr_n;
`ifdef UART_RX_PARITY_EN
    logic          par_err_q, par_err_n;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // Sync flops reset to the idle level so reset never fakes a start edge.
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_meta   <= bus.rx_in;
            rx_s      <= rx_meta;
            state_q   <= state_n;
            cyc_q     <= cyc_n;
            bit_q     <= bit_n;
            shift_q   <= shift_n;
            data_q    <= data_n;
            valid_q   <= valid_n;
            ferr_q    <= ferr_n;
            perr_q    <= perr_n;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_n;
`endif
        end
    end

    always_comb begin
        state_n   = state_q;
        cyc_n     = cyc_q;
        bit_n     = bit_q;
        shift_n   = shift_q;
        data_n    = data_q;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        perr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_n = par_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n   = S_START;
                    cyc_n     = '0;
                    bit_n     = '0;
`ifdef UART_RX_PARITY_EN
                    par_err_n = 1'b0;
`endif
                end
            end

            // Re-check the line at mid start bit; a short low pulse is a glitch.
            S_START: begin
                if (cyc_q == HALF_LAST) begin
                    cyc_n   = '0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cyc_n = cyc_q + CYC_ONE;
                end
            end

            // From mid start bit, every CPB cycles lands on the next bit's midpoint.
            S_DATA: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_n          = '0;
                    shift_n[bit_q] = rx_s;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_n = bit_q + 3'd1;
                    end
                end else begin
                    cyc_n = cyc_q + CYC_ONE;
                end
            end

`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            S_PARITY: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_n     = '0;
                    par_err_n = ^{shift_q, rx_s};
                    state_n   = S_STOP;
                end else begin
                    cyc_n = cyc_q + CYC_ONE;
                end
            end
`endif

            // Leave at mid stop bit so a zero-gap following start edge is caught.
            S_STOP: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_n = '0;
                    if (rx_s) begin
                        state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_err_q) begin
                            perr_n = 1'b1;
                        end else begin
                            data_n  = shift_q;
                            valid_n = 1'b1;
                        end
`else
                        data_n  = shift_q;
                        valid_n = 1'b1;
`endif
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end else begin
                    cyc_n = cyc_q + CYC_ONE;
                end
            end

            // A low stop bit may be a break; wait for the line to idle high again.
            S_BREAK: begin
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.data_out        = data_q;
    assign bus.valid_out       = valid_q;
    assign bus.framing_err_out = ferr_q;
    assign bus.parity_err_out  = perr_q;

endmodule
